// File: rtl/draw_lives.sv
// draw_lives: overlays a row of heart sprites (remaining lives) onto the video stream and owns the lives counter.
// Define HEART_BLINK_EN to build the frame-counted blink of the most recently lost heart.
module draw_lives #(
    parameter int          X_POS        = 10,
    parameter int          Y_POS        = 10,
    parameter int          SPACING      = 32,
    parameter int          MAX_LIVES    = 3,
    parameter int          HEART_W      = 29,
    parameter int          HEART_H      = 31,
    parameter int          BLINK_FRAMES = 64,
    parameter logic [11:0] KEY_COLOR    = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        life_lost,
    input  logic        new_game,
    input  logic [11:0] rgb_pixel,
    output logic [9:0]  pixel_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [2:0]  lives,
    output logic        game_over
);

    localparam int          TW   = 26;
    localparam logic [11:0] Y_LO = 12'(Y_POS);
    localparam logic [11:0] Y_HI = 12'(Y_POS + HEART_H);

    logic [MAX_LIVES-1:0] hit_vec;
    logic [4:0]           dx_vec [MAX_LIVES];
    logic                 in_y;
    logic [4:0]           dy_comb;
    logic                 hit_comb;
    logic [2:0]           idx_comb;
    logic [4:0]           dx_comb;

    logic [9:0]    pixel_addr_reg;
    logic          hit_s1_reg;
    logic          hit_s2_reg;
    logic [2:0]    idx_s1_reg;
    logic [2:0]    idx_s2_reg;
    logic [TW-1:0] tim_in;
    logic [TW-1:0] tim_reg [3];
    logic [11:0]   rgb_s1_reg;
    logic [11:0]   rgb_s2_reg;
    logic [11:0]   rgb_out_reg;
    logic [2:0]    lives_reg;
    logic          lose_ok;
    logic          heart_visible;
    logic          draw;

    // Stage 1: heart hit decode. Only the low 5 bits of each offset reach the ROM.
    assign in_y    = ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
    assign dy_comb = vcount_in[4:0] - Y_LO[4:0];

    generate
        for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_heart
            localparam logic [11:0] HX_LO = 12'(X_POS + gi * SPACING);
            localparam logic [11:0] HX_HI = 12'(X_POS + gi * SPACING + HEART_W);
            assign hit_vec[gi] = in_y && ({1'b0, hcount_in} >= HX_LO) && ({1'b0, hcount_in} < HX_HI);
            assign dx_vec[gi]  = hcount_in[4:0] - HX_LO[4:0];
        end
    endgenerate

    always_comb begin
        hit_comb = 1'b0;
        idx_comb = 3'd0;
        dx_comb  = 5'd0;
        for (int k = MAX_LIVES - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_comb = 1'b1;
                idx_comb = 3'(k);
                dx_comb  = dx_vec[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr_reg <= 10'd0;
            hit_s1_reg     <= 1'b0;
            idx_s1_reg     <= 3'd0;
            rgb_s1_reg     <= 12'd0;
        end else begin
            pixel_addr_reg <= hit_comb ? {dy_comb, dx_comb} : 10'd0;
            hit_s1_reg     <= hit_comb;
            idx_s1_reg     <= idx_comb;
            rgb_s1_reg     <= rgb_in;
        end
    end

    // Timing bundle {hcount, vcount, hsync, vsync, hblnk, vblnk} rides a 3-deep shift chain.
    assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tim
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) tim_reg[gi] <= '0;
                    else     tim_reg[gi] <= tim_in;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) tim_reg[gi] <= '0;
                    else     tim_reg[gi] <= tim_reg[gi-1];
                end
            end
        end
    endgenerate

    // Lives counter: new_game has priority; a hit at zero lives is ignored.
    assign lose_ok = life_lost && !new_game && (lives_reg != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lives_reg <= 3'(MAX_LIVES);
        end else if (new_game) begin
            lives_reg <= 3'(MAX_LIVES);
        end else if (lose_ok) begin
            lives_reg <= lives_reg - 3'd1;
        end
    end

`ifdef HEART_BLINK_EN
    localparam int CW = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);

    typedef enum logic {IDLE, BLINK} blink_state_t;

    blink_state_t  state_reg;
    logic [CW-1:0] frame_cnt_reg;
    logic [CW-1:0] cnt_dec;
    logic          phase_reg;
    logic          vsync_prev_reg;
    logic          frame_tick;

    assign frame_tick = vsync_in && !vsync_prev_reg;
    assign cnt_dec    = frame_cnt_reg - CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            frame_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            vsync_prev_reg <= 1'b0;
        end else begin
            vsync_prev_reg <= vsync_in;
            if (new_game) begin
                state_reg     <= IDLE;
                frame_cnt_reg <= '0;
                phase_reg     <= 1'b0;
            end else if (lose_ok) begin
                state_reg     <= BLINK;
                frame_cnt_reg <= CW'(BLINK_FRAMES);
                phase_reg     <= 1'b1;
            end else if (state_reg == BLINK && frame_tick) begin
                frame_cnt_reg <= cnt_dec;
                if (cnt_dec == '0) begin
                    state_reg <= IDLE;
                    phase_reg <= 1'b0;
                end else if (cnt_dec[2:0] == 3'd0) begin
                    phase_reg <= ~phase_reg;
                end
            end
        end
    end

    // The just-lost heart sits at index == lives and is shown only during on-phases.
    always_comb begin
        heart_visible = (idx_s2_reg < lives_reg);
        if (state_reg == BLINK && phase_reg && idx_s2_reg == lives_reg) begin
            heart_visible = 1'b1;
        end
    end
`else
    always_comb begin
        heart_visible = (idx_s2_reg < lives_reg);
    end
`endif

    // Stage 3: rgb_pixel is aligned with the stage-2 registers here.
    assign draw = hit_s2_reg && heart_visible && (rgb_pixel != KEY_COLOR)
                  && !tim_reg[1][1] && !tim_reg[1][0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_s2_reg  <= 1'b0;
            idx_s2_reg  <= 3'd0;
            rgb_s2_reg  <= 12'd0;
            rgb_out_reg <= 12'd0;
        end else begin
            hit_s2_reg  <= hit_s1_reg;
            idx_s2_reg  <= idx_s1_reg;
            rgb_s2_reg  <= rgb_s1_reg;
            rgb_out_reg <= draw ? rgb_pixel : rgb_s2_reg;
        end
    end

    assign pixel_addr = pixel_addr_reg;
    assign hcount_out = tim_reg[2][25:15];
    assign vcount_out = tim_reg[2][14:4];
    assign hsync_out  = tim_reg[2][3];
    assign vsync_out  = tim_reg[2][2];
    assign hblnk_out  = tim_reg[2][1];
    assign vblnk_out  = tim_reg[2][0];
    assign rgb_out    = rgb_out_reg;
    assign lives      = lives_reg;
    assign game_over  = (lives_reg == 3'd0);

endmodule
